// File: rtl/mac_rx_buf_ctrl.sv
// Receive frame buffer controller: writes incoming bytes into a circular RAM,
// commits good frames as length descriptors and streams them out to the host.
module mac_rx_buf_ctrl #(
   parameter int ADDR_W     = 11,
   parameter int DESC_DEPTH = 4
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              FRM_START,
   input  logic              WR_EN,
   input  logic [7:0]        WR_DATA,
   input  logic              FRM_GOOD,
   input  logic              FRM_BAD,
   output logic              RAM_WE,
   output logic [ADDR_W-1:0] RAM_WADDR,
   output logic [7:0]        RAM_WDATA,
   output logic [ADDR_W-1:0] RAM_RADDR,
   input  logic [7:0]        RAM_RDATA,
   output logic              RDONE,
   output logic              FRM_AVAIL,
   output logic [11:0]       FRM_LEN,
   input  logic              RD_START,
   output logic              RD_VALID,
   output logic [7:0]        RD_DATA,
   output logic              RD_LAST,
   output logic [7:0]        OVF_CNT
);

   localparam int PW = ADDR_W + 1;
   localparam int DW = $clog2(DESC_DEPTH);
   localparam logic [PW-1:0] BUF_SIZE  = PW'(1) << ADDR_W;
   localparam logic [DW:0]   DESC_FULL = (DW+1)'(DESC_DEPTH);

   typedef enum logic [1:0] {W_IDLE, W_FILL, W_DISC} w_state_t;
   typedef enum logic {R_IDLE, R_RUN} r_state_t;

   w_state_t w_state, w_next;
   r_state_t r_state, r_next;

   logic [PW-1:0] wr_ptr, frm_base, rd_base, rd_ptr;
   logic [11:0]   len, rd_remain;
   logic [11:0]   desc_mem [DESC_DEPTH];
   logic [DW-1:0] desc_wp, desc_rp;
   logic [DW:0]   desc_cnt;

   logic buf_full, end_evt, commit, rewind, begin_frm, drop_start, byte_wr, byte_ovf;
   logic rd_go, rd_issue, rd_final;

   // The buffer is full when the writer is a whole RAM ahead of the oldest unread frame.
   assign buf_full = ((wr_ptr - rd_base) == BUF_SIZE);

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         w_state <= W_IDLE;
         r_state <= R_IDLE;
      end else begin
         w_state <= w_next;
         r_state <= r_next;
      end
   end

   // An end event is resolved before a coincident start, so the start sees the post-commit FIFO level.
   always_comb begin
      w_next     = w_state;
      end_evt    = 1'b0;
      commit     = 1'b0;
      rewind     = 1'b0;
      begin_frm  = 1'b0;
      drop_start = 1'b0;
      byte_wr    = 1'b0;
      byte_ovf   = 1'b0;
      case (w_state)
         W_FILL: begin
            if (FRM_GOOD || FRM_BAD) begin
               end_evt = 1'b1;
               w_next  = W_IDLE;
               if (FRM_GOOD && len != 12'd0) commit = 1'b1;
               else                          rewind = 1'b1;
            end else if (FRM_START) begin
               rewind = 1'b1;
            end else if (WR_EN) begin
               if (buf_full) begin
                  byte_ovf = 1'b1;
                  rewind   = 1'b1;
                  w_next   = W_DISC;
               end else begin
                  byte_wr = 1'b1;
               end
            end
         end
         W_DISC: begin
            if (FRM_GOOD || FRM_BAD) begin
               end_evt = 1'b1;
               w_next  = W_IDLE;
            end
         end
         default: ;
      endcase
      if (FRM_START) begin
         if ((desc_cnt + (DW+1)'(commit)) == DESC_FULL) begin
            drop_start = 1'b1;
            w_next     = W_DISC;
         end else begin
            begin_frm = 1'b1;
            w_next    = W_FILL;
         end
      end
   end

   always_comb begin
      RAM_WE    = byte_wr;
      RAM_WADDR = wr_ptr[ADDR_W-1:0];
      RAM_WDATA = WR_DATA;
   end

   always_comb begin
      r_next = r_state;
      case (r_state)
         R_IDLE:  if (RD_START && desc_cnt != '0) r_next = R_RUN;
         R_RUN:   if (rd_remain == 12'd1) r_next = R_IDLE;
         default: r_next = R_IDLE;
      endcase
   end

   always_comb begin
      FRM_AVAIL = (desc_cnt != '0) && (r_state == R_IDLE);
      FRM_LEN   = (desc_cnt != '0) ? desc_mem[desc_rp] : 12'd0;
      rd_go     = RD_START && FRM_AVAIL;
      rd_issue  = (r_state == R_RUN);
      rd_final  = rd_issue && (rd_remain == 12'd1);
      RAM_RADDR = rd_ptr[ADDR_W-1:0];
      RD_DATA   = RAM_RDATA;
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         wr_ptr    <= '0;
         frm_base  <= '0;
         len       <= '0;
         rd_base   <= '0;
         rd_ptr    <= '0;
         rd_remain <= '0;
         desc_wp   <= '0;
         desc_rp   <= '0;
         desc_cnt  <= '0;
         OVF_CNT   <= '0;
         RDONE     <= 1'b0;
         RD_VALID  <= 1'b0;
         RD_LAST   <= 1'b0;
      end else begin
         if (rewind)       wr_ptr <= frm_base;
         else if (byte_wr) wr_ptr <= wr_ptr + PW'(1);
         if (begin_frm) begin
            frm_base <= rewind ? frm_base : wr_ptr;
            len      <= '0;
         end else if (byte_wr) begin
            len <= len + 12'd1;
         end
         if ((byte_ovf || drop_start) && OVF_CNT != 8'hFF) OVF_CNT <= OVF_CNT + 8'd1;
         RDONE <= end_evt;
         if (commit)   desc_wp <= desc_wp + DW'(1);
         if (rd_final) desc_rp <= desc_rp + DW'(1);
         desc_cnt <= desc_cnt + (DW+1)'(commit) - (DW+1)'(rd_final);
         if (rd_go) begin
            rd_remain <= FRM_LEN;
         end else if (rd_issue) begin
            rd_remain <= rd_remain - 12'd1;
            rd_ptr    <= rd_ptr + PW'(1);
         end
         if (rd_final) rd_base <= rd_ptr + PW'(1);
         RD_VALID <= rd_issue;
         RD_LAST  <= rd_final;
      end
   end

   always_ff @(posedge CLK) begin
      if (commit) desc_mem[desc_wp] <= len;
   end

endmodule

// File: doc/mac_rx_buf_ctrl.md
MAC_RX_BUF_CTRL -- requirements
Module: mac_rx_buf_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, frame-buffer RAM address width (2^ADDR_W bytes).
REQ-002 SHALL have parameter DESC_DEPTH, default 4, descriptor FIFO depth (power of 2).
REQ-003 SHALL have port CLK  in  1  system clock, all logic on rising edge.
REQ-004 SHALL have port RESET  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port FRM_START  in  1  one-cycle pulse from RX control: new frame begins.
REQ-006 SHALL have port WR_EN  in  1  received byte valid.
REQ-007 SHALL have port WR_DATA  in  8  received byte.
REQ-008 SHALL have port FRM_GOOD  in  1  one-cycle pulse: frame ended, CRC and address OK.
REQ-009 SHALL have port FRM_BAD  in  1  one-cycle pulse: frame ended, discard.
REQ-010 SHALL have ports RAM_WE out 1, RAM_WADDR out ADDR_W, RAM_WDATA out 8, RAM_RADDR out ADDR_W, RAM_RDATA in 8 (simple dual-port RAM, 1-cycle read latency).
REQ-011 SHALL have port RDONE  out  1  one-cycle pulse: frame commit/discard finished, RX control may return to idle.
REQ-012 SHALL have ports FRM_AVAIL out 1 (committed frame waiting), FRM_LEN out 12 (head frame byte count).
REQ-013 SHALL have port RD_START  in  1  host pulse: start reading head frame.
REQ-014 SHALL have ports RD_VALID out 1, RD_DATA out 8, RD_LAST out 1 (read stream, no backpressure).
REQ-015 SHALL have port OVF_CNT  out  8  saturating count of frames dropped for lack of space.

Function
REQ-016 Pointers wr_ptr, frm_base, rd_base, rd_ptr SHALL be ADDR_W+1 bits; RAM addresses use low ADDR_W bits; wrap-around is natural modulo.
REQ-017 Write FSM SHALL have states W_IDLE, W_FILL, W_DISC.
REQ-018 W_IDLE + FRM_START: if descriptor FIFO full -> W_DISC, OVF_CNT+1; else frm_base<=wr_ptr, len<=0, -> W_FILL.
REQ-019 In W_FILL, WR_EN with (wr_ptr - rd_base) < 2^ADDR_W SHALL assert RAM_WE same cycle at wr_ptr, then wr_ptr+1, len+1.
REQ-020 In W_FILL, WR_EN with buffer full SHALL rewind wr_ptr<=frm_base, OVF_CNT+1, -> W_DISC.
REQ-021 FRM_GOOD in W_FILL with len>0 SHALL push len into descriptor FIFO, keep wr_ptr, pulse RDONE next cycle, -> W_IDLE.
REQ-022 FRM_GOOD with len==0, or FRM_BAD, in W_FILL SHALL rewind wr_ptr<=frm_base, pulse RDONE, -> W_IDLE.
REQ-023 In W_DISC, WR_EN SHALL be ignored; FRM_GOOD or FRM_BAD SHALL pulse RDONE, -> W_IDLE.
REQ-024 FRM_START in W_FILL or W_DISC SHALL abort current frame (rewind wr_ptr<=frm_base) and restart per REQ-018; no RDONE for the aborted frame.
REQ-025 FRM_START and FRM_GOOD/FRM_BAD in same cycle: end event processed first, then start; RDONE still pulses.
REQ-026 OVF_CNT SHALL saturate at 255.
REQ-027 Read FSM SHALL have states R_IDLE, R_RUN; FRM_AVAIL = descriptor FIFO not empty AND R_IDLE; FRM_LEN = head descriptor.
REQ-028 RD_START while FRM_AVAIL SHALL enter R_RUN, issue RAM_RADDR=rd_ptr, incrementing once per cycle for FRM_LEN cycles; RD_START otherwise ignored.
REQ-029 RD_VALID/RD_DATA SHALL follow each address by exactly 1 cycle; RD_LAST with the final byte.
REQ-030 On final address issue, descriptor SHALL pop and rd_base<=rd_ptr+1 (space freed); -> R_IDLE.
REQ-031 Simultaneous descriptor push and pop SHALL keep count unchanged, no loss.
REQ-032 Uncommitted bytes SHALL never be visible to the read side.

Reset
REQ-033 RESET low SHALL force W_IDLE, R_IDLE, all pointers 0, descriptor FIFO empty, OVF_CNT 0, RAM_WE/RDONE/RD_VALID/RD_LAST/FRM_AVAIL 0, FRM_LEN 0, mid-frame data discarded.

Verification
REQ-034 FRM_START, 64 bytes 0x00..0x3F, FRM_GOOD -> RDONE 1 cycle later, FRM_AVAIL=1, FRM_LEN=64; RD_START -> 64 RD_VALID bytes 0x00..0x3F, RD_LAST on 0x3F, FRM_AVAIL=0.
REQ-035 60-byte frame then FRM_BAD -> RDONE pulse, FRM_AVAIL stays 0, wr_ptr back to start; next good frame stored at same address.
REQ-036 ADDR_W=11: write frames of 1500 bytes without reading until full -> second frame overflows, OVF_CNT=1, first frame still readable with FRM_LEN=1500.
REQ-037 Five good 64-byte frames, no reads -> fifth dropped (descriptor full), OVF_CNT=1; read four, all intact.
REQ-038 Frames straddling address 2047->0 -> read data byte-exact across wrap.
REQ-039 RESET asserted mid-frame and mid-read -> all outputs at reset values next cycle, FRM_AVAIL=0 after release.
